washing_machine: RTL and testbench

- Bank of LANES independent washing-machine controllers sharing one clock and reset.
- Each lane sequences one full wash: door check, fill, detergent, wash, drain, rinse fill, rinse, drain, spin.
- Sensor and timer inputs come from plant/timer logic; actuator and status outputs drive valves, motor, lock and status.
- Bit i of every per-lane vector belongs to lane i.

---
 rtl/washing_machine_pkg.sv | 25 ++
 rtl/washing_machine_lane.sv | 140 ++++++++++++++
 rtl/washing_machine.sv | 64 ++++++
 tb/tb_washing_machine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/washing_machine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : washing_machine_pkg
// Description : Shared types and constants for the washing-machine controller
//               bank: the per-lane state encoding and the default lane count.
// Revision    : 1.0 - initial release
// ============================================================================
package washing_machine_pkg;

    // Default number of independent controller lanes in the bank.
    localparam int c_DEFAULT_LANES = 128;

    // Per-lane controller state, explicit 3-bit encoding. Codes 6 and 7 are
    // unused; the lane FSM treats them as illegal and recovers to CHECK_DOOR.
    typedef enum logic [2:0] {
        CHECK_DOOR    = 3'd0,
        FILL          = 3'd1,
        ADD_DETERGENT = 3'd2,
        CYCLE         = 3'd3,
        DRAIN         = 3'd4,
        SPIN          = 3'd5
    } wm_state_t;

endpackage : washing_machine_pkg
`default_nettype wire

// File: rtl/washing_machine_lane.sv
`default_nettype none
// ============================================================================
// Module      : washing_machine_lane
// Description : One washing-machine controller. Moore FSM that sequences
//               door check, fill, detergent, wash, drain, rinse fill, rinse,
//               drain and spin. Two flags track program progress: soap
//               (detergent phase done) and rinse (rinse phase entered).
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               i_*                - scalar sensor / timer inputs
//               o_doorlock/o_motoron/o_fillvalve/o_drainvalve - actuators,
//                                    decoded from state only
//               o_done             - registered one-cycle end-of-program pulse
//               o_soap, o_rinse    - progress flags
// Revision    : 1.0 - initial release
// ============================================================================
module washing_machine_lane
    import washing_machine_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_closedoor,
    input  logic i_startmachine,
    input  logic i_filledmachine,
    input  logic i_detergentadded,
    input  logic i_cycle_timeout,
    input  logic i_waterdrained,
    input  logic i_spin_timeout,
    output logic o_doorlock,
    output logic o_motoron,
    output logic o_fillvalve,
    output logic o_drainvalve,
    output logic o_done,
    output logic o_soap,
    output logic o_rinse
);

    wm_state_t r_state;
    logic      r_soap;
    logic      r_rinse;
    logic      r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CHECK_DOOR;
            r_soap  <= 1'b0;
            r_rinse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // done is a pulse: only the SPIN exit raises it for one cycle
            r_done <= 1'b0;
            case (r_state)
                CHECK_DOOR: begin
                    if (i_startmachine && i_closedoor) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    // the rinse fill skips detergent because soap is already set
                    if (i_filledmachine) begin
                        r_state <= r_soap ? CYCLE : ADD_DETERGENT;
                    end
                end
                ADD_DETERGENT: begin
                    if (i_detergentadded) begin
                        r_soap  <= 1'b1;
                        r_state <= CYCLE;
                    end
                end
                CYCLE: begin
                    if (i_cycle_timeout) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // first drain goes back for the rinse fill, second to spin
                    if (i_waterdrained) begin
                        if (!r_rinse) begin
                            r_rinse <= 1'b1;
                            r_state <= FILL;
                        end else begin
                            r_state <= SPIN;
                        end
                    end
                end
                SPIN: begin
                    if (i_spin_timeout) begin
                        r_state <= CHECK_DOOR;
                        r_soap  <= 1'b0;
                        r_rinse <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= CHECK_DOOR;
                    r_soap  <= 1'b0;
                    r_rinse <= 1'b0;
                end
            endcase
        end
    end

    // Actuators depend on state only, so no sensor can glitch an output.
    always_comb begin
        o_doorlock   = 1'b0;
        o_motoron    = 1'b0;
        o_fillvalve  = 1'b0;
        o_drainvalve = 1'b0;
        case (r_state)
            FILL: begin
                o_doorlock  = 1'b1;
                o_fillvalve = 1'b1;
            end
            ADD_DETERGENT: begin
                o_doorlock = 1'b1;
            end
            CYCLE: begin
                o_doorlock = 1'b1;
                o_motoron  = 1'b1;
            end
            DRAIN: begin
                o_doorlock   = 1'b1;
                o_drainvalve = 1'b1;
            end
            SPIN: begin
                o_doorlock   = 1'b1;
                o_motoron    = 1'b1;
                o_drainvalve = 1'b1;
            end
            default: begin
                o_doorlock = 1'b0;
            end
        endcase
    end

    assign o_done  = r_done;
    assign o_soap  = r_soap;
    assign o_rinse = r_rinse;

endmodule : washing_machine_lane
`default_nettype wire

// File: rtl/washing_machine.sv
`default_nettype none
// ============================================================================
// Module      : washing_machine
// Description : Bank of LANES independent washing-machine controllers sharing
//               one clock and asynchronous active-low reset. Bit i of every
//               per-lane vector belongs to lane i.
// Ports       : clk, reset              - clock, async active-low reset
//               closedoor[2*LANES]      - door sensors; only [LANES-1:0] used
//               startmachine .. spin_timeout_check [LANES] - lane inputs
//               doorlock/motoron/fillvalue/drainvalue_check [LANES] - actuators
//               done [LANES]            - end-of-program pulse
//               detergent_wash, checkwater_wash [LANES] - progress flags
// Revision    : 1.0 - initial release
// ============================================================================
module washing_machine
    import washing_machine_pkg::*;
#(
    parameter int LANES = c_DEFAULT_LANES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*LANES-1:0] closedoor,
    input  logic [LANES-1:0]   startmachine,
    input  logic [LANES-1:0]   filledmachine,
    input  logic [LANES-1:0]   detergentadded,
    input  logic [LANES-1:0]   machinecycle_timeout,
    input  logic [LANES-1:0]   waterdrained,
    input  logic [LANES-1:0]   spin_timeout_check,
    output logic [LANES-1:0]   doorlock_check,
    output logic [LANES-1:0]   motoron_check,
    output logic [LANES-1:0]   fillvalue_check,
    output logic [LANES-1:0]   drainvalue_check,
    output logic [LANES-1:0]   done,
    output logic [LANES-1:0]   detergent_wash,
    output logic [LANES-1:0]   checkwater_wash
);

    // The upper half of the door bus carries no meaning for this bank.
    logic w_unused_closedoor_hi;
    assign w_unused_closedoor_hi = ^closedoor[2*LANES-1:LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        washing_machine_lane u_lane (
            .clk              (clk),
            .rst_n            (reset),
            .i_closedoor      (closedoor[gi]),
            .i_startmachine   (startmachine[gi]),
            .i_filledmachine  (filledmachine[gi]),
            .i_detergentadded (detergentadded[gi]),
            .i_cycle_timeout  (machinecycle_timeout[gi]),
            .i_waterdrained   (waterdrained[gi]),
            .i_spin_timeout   (spin_timeout_check[gi]),
            .o_doorlock       (doorlock_check[gi]),
            .o_motoron        (motoron_check[gi]),
            .o_fillvalve      (fillvalue_check[gi]),
            .o_drainvalve     (drainvalue_check[gi]),
            .o_done           (done[gi]),
            .o_soap           (detergent_wash[gi]),
            .o_rinse          (checkwater_wash[gi])
        );
    end

endmodule : washing_machine
`default_nettype wire

// File: tb/tb_washing_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_washing_machine
// Description : Self-checking bench for the washing_machine bank. A program-
//               step model (steps 0..8 of the wash program) predicts every
//               output vector; expectations are queued by the stimulus and
//               popped by an independent monitor each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_washing_machine;

    localparam int LANES = 128;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [2*LANES-1:0] closedoor = '0;
    logic [LANES-1:0]   startmachine = '0;
    logic [LANES-1:0]   filledmachine = '0;
    logic [LANES-1:0]   detergentadded = '0;
    logic [LANES-1:0]   machinecycle_timeout = '0;
    logic [LANES-1:0]   waterdrained = '0;
    logic [LANES-1:0]   spin_timeout_check = '0;
    logic [LANES-1:0]   doorlock_check;
    logic [LANES-1:0]   motoron_check;
    logic [LANES-1:0]   fillvalue_check;
    logic [LANES-1:0]   drainvalue_check;
    logic [LANES-1:0]   done;
    logic [LANES-1:0]   detergent_wash;
    logic [LANES-1:0]   checkwater_wash;

    always #5 clk = ~clk;

    washing_machine #(.LANES(LANES)) dut (
        .clk                  (clk),
        .reset                (reset),
        .closedoor            (closedoor),
        .startmachine         (startmachine),
        .filledmachine        (filledmachine),
        .detergentadded       (detergentadded),
        .machinecycle_timeout (machinecycle_timeout),
        .waterdrained         (waterdrained),
        .spin_timeout_check   (spin_timeout_check),
        .doorlock_check       (doorlock_check),
        .motoron_check        (motoron_check),
        .fillvalue_check      (fillvalue_check),
        .drainvalue_check     (drainvalue_check),
        .done                 (done),
        .detergent_wash       (detergent_wash),
        .checkwater_wash      (checkwater_wash)
    );

    typedef struct packed {
        logic [LANES-1:0] lock;
        logic [LANES-1:0] motor;
        logic [LANES-1:0] fill;
        logic [LANES-1:0] drain;
        logic [LANES-1:0] done;
        logic [LANES-1:0] soap;
        logic [LANES-1:0] rinse;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    // Program step per lane: 0 idle, 1 fill, 2 detergent, 3 wash, 4 drain,
    // 5 rinse fill, 6 rinse, 7 rinse drain, 8 spin.
    int   step[LANES];

    task automatic check_vec(input string name, input logic [LANES-1:0] act,
                             input logic [LANES-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Which input a lane is waiting on at a given program step.
    function automatic logic step_trigger(input int i, input int s);
        case (s)
            0:       return startmachine[i] & closedoor[i];
            1, 5:    return filledmachine[i];
            2:       return detergentadded[i];
            3, 6:    return machinecycle_timeout[i];
            4, 7:    return waterdrained[i];
            default: return spin_timeout_check[i];
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently driven,
    // then queue the outputs expected after that edge.
    task automatic step_model();
        exp_t e;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!reset) begin
                step[i] = 0;
            end else if (step_trigger(i, step[i])) begin
                if (step[i] == 8) begin
                    e.done[i] = 1'b1;
                    step[i]   = 0;
                end else begin
                    step[i] = step[i] + 1;
                end
            end
            e.lock[i]  = (step[i] != 0);
            e.fill[i]  = (step[i] == 1) || (step[i] == 5);
            e.motor[i] = (step[i] == 3) || (step[i] == 6) || (step[i] == 8);
            e.drain[i] = (step[i] == 4) || (step[i] == 7) || (step[i] == 8);
            e.soap[i]  = (step[i] >= 3);
            e.rinse[i] = (step[i] >= 5);
        end
        sb_q.push_back(e);
    endtask

    function automatic logic [LANES-1:0] rnd_vec();
        logic [LANES-1:0] v;
        for (int w = 0; w < LANES / 32; w++) begin
            v[w*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic drive(input logic r, input logic [2*LANES-1:0] cd,
                         input logic [LANES-1:0] st, input logic [LANES-1:0] fl,
                         input logic [LANES-1:0] de, input logic [LANES-1:0] to,
                         input logic [LANES-1:0] dr, input logic [LANES-1:0] sp);
        @(negedge clk);
        reset                = r;
        closedoor            = cd;
        startmachine         = st;
        filledmachine        = fl;
        detergentadded       = de;
        machinecycle_timeout = to;
        waterdrained         = dr;
        spin_timeout_check   = sp;
        step_model();
    endtask

    task automatic drive_random(input logic r, input logic [LANES-1:0] st_mask);
        drive(r, {rnd_vec(), rnd_vec()}, rnd_vec() & st_mask, rnd_vec(), rnd_vec(),
              rnd_vec(), rnd_vec(), rnd_vec());
    endtask

    // Present only the trigger for program step s on one lane; door bit is
    // toggled to show that opening the door mid-program has no effect.
    task automatic drive_lane_step(input int lane, input int s);
        logic [LANES-1:0] b;
        logic [LANES-1:0] z;
        logic [LANES-1:0] cd;
        b      = '0;
        z      = '0;
        b[lane] = 1'b1;
        cd     = (s == 0 || s[0]) ? b : z;
        case (s)
            0:       drive(1'b1, {z, cd}, b, z, z, z, z, z);
            1, 5:    drive(1'b1, {z, cd}, z, b, z, z, z, z);
            2:       drive(1'b1, {z, cd}, z, z, b, z, z, z);
            3, 6:    drive(1'b1, {z, cd}, z, z, z, b, z, z);
            4, 7:    drive(1'b1, {z, cd}, z, z, z, z, b, z);
            default: drive(1'b1, {z, cd}, z, z, z, z, z, b);
        endcase
    endtask

    task automatic drive_idle();
        drive(1'b1, '0, '0, '0, '0, '0, '0, '0);
    endtask

    // Monitor: every cycle the bank presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_vec("doorlock",   doorlock_check,   e.lock);
                check_vec("motoron",    motoron_check,    e.motor);
                check_vec("fillvalve",  fillvalue_check,  e.fill);
                check_vec("drainvalve", drainvalue_check, e.drain);
                check_vec("done",       done,             e.done);
                check_vec("detergent",  detergent_wash,   e.soap);
                check_vec("checkwater", checkwater_wash,  e.rinse);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES-1:0] ones;
        logic [LANES-1:0] zeros;
        logic [LANES-1:0] lane5;
        ones  = '1;
        zeros = '0;
        lane5 = '0;
        lane5[5] = 1'b1;
        for (int i = 0; i < LANES; i++) step[i] = 0;

        // Reset held with random inputs, then idle with start low.
        drive_random(1'b0, ones);
        drive_random(1'b0, ones);
        for (int k = 0; k < 5; k++) drive_random(1'b1, zeros);

        // Full program on lane 0, one sensor pulse per step with waits.
        for (int s = 0; s <= 8; s++) begin
            drive_idle();
            drive_lane_step(0, s);
        end
        drive_idle();
        drive_idle();

        // Lane 5 with everything held high: done every 9 cycles.
        for (int k = 0; k < 27; k++) begin
            drive(1'b1, {ones, ones}, lane5, ones, ones, ones, ones, ones);
        end

        // Door gating: start everywhere, only the ignored upper door bits set.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, {ones, zeros}, ones, rnd_vec(), rnd_vec(), rnd_vec(),
                  rnd_vec(), rnd_vec());
        end

        // Randomized traffic across all lanes.
        for (int k = 0; k < 1500; k++) drive_random(1'b1, ones);

        // Bring lane 0 back to idle via reset, then into CYCLE.
        drive_random(1'b0, ones);
        for (int s = 0; s <= 2; s++) drive_lane_step(0, s);

        // Asynchronous reset between edges while lane 0 runs its motor.
        @(posedge clk);
        #3;
        check_vec("pre_reset_motor0", {{(LANES-1){1'b0}}, motoron_check[0]},
                  {{(LANES-1){1'b0}}, 1'b1});
        reset = 1'b0;
        #1;
        check_vec("async_doorlock",   doorlock_check,  zeros);
        check_vec("async_motoron",    motoron_check,   zeros);
        check_vec("async_detergent",  detergent_wash,  zeros);
        check_vec("async_checkwater", checkwater_wash, zeros);
        for (int i = 0; i < LANES; i++) step[i] = 0;
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) drive_idle();
        for (int k = 0; k < 20; k++) drive_random(1'b1, ones);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_washing_machine
`default_nettype wire
